// File: rtl/md_cart_port_arbiter_pkg.sv
// Shared types and constants for the cartridge port arbiter: FSM states,
// default address width, fetch timeout and the open-bus read value.
package md_cart_pkg;

  localparam int          CART_ADDR_W   = 21;
  localparam int          CART_TIMEOUT  = 48;
  localparam logic [15:0] CART_OPEN_BUS = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RD_DONE
  } arb_state_t;

endpackage

// File: rtl/md_cart_port_arbiter_if.sv
// Word-wide memory port with req/ack handshake. The arbiter is the master;
// the SDRAM/BRAM controller is the slave.
interface md_cart_port_arbiter_if
  import md_cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/md_cart_port_arbiter_word_cache.sv
// Single-word last-read cache: one tag/word pair with a valid bit, filled by
// completed reads and invalidated when a write lands on the cached address.
module md_cart_word_cache
  import md_cart_pkg::*;
#(
  parameter int ADDR_W = CART_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_tag,
  input  logic [15:0]       fill_word,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [15:0]       word
);

  logic              valid_reg;
  logic [ADDR_W-1:0] tag_reg;
  logic [15:0]       word_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      word_reg  <= '0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_tag;
      word_reg  <= fill_word;
    end else if (inval && (tag_reg == inval_addr)) begin
      valid_reg <= 1'b0;
    end
  end

  assign hit  = valid_reg && (tag_reg == lookup_addr);
  assign word = word_reg;

endmodule

// File: rtl/md_cart_port_arbiter.sv
// Arbitrates one memory port between 68k cartridge reads and a ROM loader,
// holding cart_data for the bus cycle and aborting fetches that never ack.
module md_cart_port_arbiter
  import md_cart_pkg::*;
#(
  parameter int          ADDR_W   = CART_ADDR_W,
  parameter int          TIMEOUT  = CART_TIMEOUT,
  parameter logic [15:0] OPEN_BUS = CART_OPEN_BUS
) (
  input  logic                   MCLK,
  input  logic                   SRES,
  input  logic [ADDR_W-1:0]      cart_address,
  input  logic                   cart_cs,
  input  logic                   cart_oe,
  output logic [15:0]            cart_data,
  input  logic                   ld_valid,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [15:0]            ld_data,
  output logic                   ld_ready,
  md_cart_port_arbiter_if.master mem,
  output logic                   err_timeout,
  output logic                   busy
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

  arb_state_t        state_reg, state_next;
  logic              strobe_q_reg;
  logic              pending_reg, pending_next;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
  logic [15:0]       cart_data_reg, cart_data_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [15:0]       mem_wdata_reg, mem_wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic              ld_ready_reg, ld_ready_next;

  logic              strobe;
  logic              cart_edge;
  logic              cache_hit;
  logic [15:0]       cache_word;
  logic              cache_fill;
  logic              cache_inval;

  assign strobe    = cart_cs & cart_oe;
  assign cart_edge = strobe & ~strobe_q_reg;

  md_cart_word_cache #(
    .ADDR_W (ADDR_W)
  ) u_cache (
    .clk         (MCLK),
    .rst_n       (SRES),
    .fill        (cache_fill),
    .fill_tag    (mem_addr_reg),
    .fill_word   (mem.mem_rdata),
    .inval       (cache_inval),
    .inval_addr  (mem_addr_reg),
    .lookup_addr (rd_addr_reg),
    .hit         (cache_hit),
    .word        (cache_word)
  );

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state_reg     <= IDLE;
      strobe_q_reg  <= 1'b0;
      pending_reg   <= 1'b0;
      rd_addr_reg   <= '0;
      cart_data_reg <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cnt_reg       <= '0;
      err_reg       <= 1'b0;
      ld_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      strobe_q_reg  <= strobe;
      pending_reg   <= pending_next;
      rd_addr_reg   <= rd_addr_next;
      cart_data_reg <= cart_data_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      cnt_reg       <= cnt_next;
      err_reg       <= err_next;
      ld_ready_reg  <= ld_ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg;
    rd_addr_next   = rd_addr_reg;
    cart_data_next = cart_data_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    ld_ready_next  = 1'b0;
    cache_fill     = 1'b0;
    cache_inval    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          pending_next = 1'b0;
          if (cache_hit) begin
            cart_data_next = cache_word;
          end else begin
            mem_req_next  = 1'b1;
            mem_we_next   = 1'b0;
            mem_addr_next = rd_addr_reg;
            cnt_next      = '0;
            state_next    = RD_WAIT;
          end
        // A cart edge this cycle becomes pending next cycle and must win the
        // tie; the ld_ready cycle is skipped so a held ld_valid is not reissued.
        end else if (ld_valid && !cart_edge && !ld_ready_reg) begin
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b1;
          mem_addr_next  = ld_addr;
          mem_wdata_next = ld_data;
          cnt_next       = '0;
          state_next     = WR_WAIT;
        end
      end

      RD_WAIT: begin
        if (mem.mem_ack) begin
          cart_data_next = mem.mem_rdata;
          cache_fill     = 1'b1;
          mem_req_next   = 1'b0;
          state_next     = RD_DONE;
        end else if (cnt_reg == CNT_TO) begin
          mem_req_next   = 1'b0;
          cart_data_next = OPEN_BUS;
          err_next       = 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        end
      end

      WR_WAIT: begin
        if (mem.mem_ack) begin
          mem_req_next  = 1'b0;
          ld_ready_next = 1'b1;
          cache_inval   = 1'b1;
          state_next    = IDLE;
        end else if (cnt_reg == CNT_TO) begin
          mem_req_next = 1'b0;
          err_next     = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        end
      end

      RD_DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Newest strobe always replaces an unserved one.
    if (cart_edge) begin
      pending_next = 1'b1;
      rd_addr_next = cart_address;
    end
  end

  assign cart_data     = cart_data_reg;
  assign ld_ready      = ld_ready_reg;
  assign err_timeout   = err_reg;
  assign busy          = (state_reg != IDLE);
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_md_cart_port_arbiter.sv
// Bench for md_cart_port_arbiter: directed plan scenarios followed by random
// reads/writes checked against a memory-plus-last-read reference model.
module tb_md_cart_port_arbiter;
  import md_cart_pkg::*;

  localparam int AW = CART_ADDR_W;
  localparam int TO = CART_TIMEOUT;

  logic          MCLK = 1'b0;
  logic          SRES = 1'b0;
  logic [AW-1:0] cart_address = '0;
  logic          cart_cs = 1'b0;
  logic          cart_oe = 1'b0;
  logic [15:0]   cart_data;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [15:0]   ld_data = '0;
  logic          ld_ready;
  logic          err_timeout;
  logic          busy;

  md_cart_port_arbiter_if #(.ADDR_W(AW)) mem_bus ();

  md_cart_port_arbiter dut (
    .MCLK         (MCLK),
    .SRES         (SRES),
    .cart_address (cart_address),
    .cart_cs      (cart_cs),
    .cart_oe      (cart_oe),
    .cart_data    (cart_data),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .mem          (mem_bus),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  always #5 MCLK = ~MCLK;

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents plus the address of the last good read.
  logic [15:0] mem_model [int];
  bit          c_valid = 1'b0;
  int          c_addr  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_val(input int a);
    if (mem_model.exists(a)) return mem_model[a];
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (mem_bus.mem_req !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check_val("req_seen", {31'd0, mem_bus.mem_req}, 32'd1);
  endtask

  task automatic do_read(input int a, input int d, input bit do_to);
    bit          exp_hit;
    logic [15:0] exp_d;
    logic [15:0] exp_hold;
    int          n;
    exp_hit = c_valid && (c_addr == a);
    exp_d   = mem_val(a);
    cart_address = AW'(a);
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    step();
    check_val("rd_req_early", {31'd0, mem_bus.mem_req}, 32'd0);
    step();
    if (exp_hit) begin
      check_val("hit_no_req", {31'd0, mem_bus.mem_req}, 32'd0);
      check_val("hit_data", {16'd0, cart_data}, {16'd0, exp_d});
      check_val("hit_busy", {31'd0, busy}, 32'd0);
      exp_hold = exp_d;
    end else begin
      check_val("miss_req", {31'd0, mem_bus.mem_req}, 32'd1);
      check_val("miss_we", {31'd0, mem_bus.mem_we}, 32'd0);
      check_val("miss_addr", 32'(mem_bus.mem_addr), 32'(a));
      if (do_to) begin
        n = 0;
        while (mem_bus.mem_req === 1'b1 && n < 200) begin
          step();
          n++;
        end
        check_val("to_req_len", 32'(n), 32'(TO + 1));
        check_val("to_data", {16'd0, cart_data}, {16'd0, CART_OPEN_BUS});
        check_val("to_err", {31'd0, err_timeout}, 32'd1);
        exp_hold = CART_OPEN_BUS;
      end else begin
        repeat (d) step();
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = exp_d;
        step();
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'($urandom);
        check_val("miss_data", {16'd0, cart_data}, {16'd0, exp_d});
        check_val("miss_req_low", {31'd0, mem_bus.mem_req}, 32'd0);
        c_valid  = 1'b1;
        c_addr   = a;
        exp_hold = exp_d;
      end
    end
    cart_cs = 1'b0;
    cart_oe = 1'($urandom);
    step();
    check_val("rd_hold", {16'd0, cart_data}, {16'd0, exp_hold});
    step();
    $display("read  addr=%06h hit=%0d timeout=%0d data=%04h", a, exp_hit, do_to, cart_data);
  endtask

  task automatic wr_finish(input int a, input logic [15:0] data, input int d, output int n);
    wait_req(n);
    check_val("wr_we", {31'd0, mem_bus.mem_we}, 32'd1);
    check_val("wr_addr", 32'(mem_bus.mem_addr), 32'(a));
    check_val("wr_wdata", {16'd0, mem_bus.mem_wdata}, {16'd0, data});
    check_val("wr_ready_early", {31'd0, ld_ready}, 32'd0);
    repeat (d) step();
    mem_bus.mem_ack = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0;
    check_val("wr_ready", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b0;
    step();
    check_val("wr_ready_pulse", {31'd0, ld_ready}, 32'd0);
    check_val("wr_no_reissue", {31'd0, mem_bus.mem_req}, 32'd0);
    mem_model[a] = data;
    if (c_addr == a) c_valid = 1'b0;
    step();
    $display("write addr=%06h data=%04h delay=%0d", a, data, d);
  endtask

  task automatic do_write(input int a, input logic [15:0] data, input int d);
    int n;
    ld_valid = 1'b1;
    ld_addr  = AW'(a);
    ld_data  = data;
    wr_finish(a, data, d, n);
  endtask

  initial begin
    int n;
    int a;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset held with random inputs toggling.
    for (int i = 0; i < 6; i++) begin
      cart_address      = AW'($urandom);
      cart_cs           = 1'($urandom);
      cart_oe           = 1'($urandom);
      ld_valid          = 1'($urandom);
      ld_addr           = AW'($urandom);
      ld_data           = 16'($urandom);
      mem_bus.mem_ack   = 1'($urandom);
      mem_bus.mem_rdata = 16'($urandom);
      step();
    end
    check_val("rst_cart_data", {16'd0, cart_data}, 32'd0);
    check_val("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
    check_val("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
    check_val("rst_mem_wdata", {16'd0, mem_bus.mem_wdata}, 32'd0);
    check_val("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check_val("rst_err", {31'd0, err_timeout}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    cart_cs = 1'b0; cart_oe = 1'b0; ld_valid = 1'b0;
    mem_bus.mem_ack = 1'b0;
    step();
    SRES = 1'b1;
    step();

    // Miss, hit, write with invalidation, re-miss.
    mem_model[32'h00100] = 16'h4E71;
    do_read(32'h00100, 5, 1'b0);
    do_read(32'h00100, 0, 1'b0);
    do_write(32'h00100, 16'hBEEF, 2);
    do_read(32'h00100, 1, 1'b0);

    // Same-cycle tie: read issued first, write after RD_DONE.
    cart_address = AW'(32'h00200);
    cart_cs = 1'b1; cart_oe = 1'b1;
    ld_valid = 1'b1; ld_addr = AW'(32'h00300); ld_data = 16'h1234;
    step();
    step();
    check_val("tie_rd_req", {31'd0, mem_bus.mem_req}, 32'd1);
    check_val("tie_rd_we", {31'd0, mem_bus.mem_we}, 32'd0);
    check_val("tie_rd_addr", 32'(mem_bus.mem_addr), 32'h00200);
    repeat (2) step();
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = mem_val(32'h00200);
    step();
    mem_bus.mem_ack = 1'b0;
    check_val("tie_rd_data", {16'd0, cart_data}, {16'd0, mem_val(32'h00200)});
    check_val("tie_no_ready", {31'd0, ld_ready}, 32'd0);
    c_valid = 1'b1; c_addr = 32'h00200;
    cart_cs = 1'b0;
    $display("read  addr=000200 tie with loader data=%04h", cart_data);
    wr_finish(32'h00300, 16'h1234, 1, n);
    check_val("tie_wr_gap", 32'(n), 32'd2);

    // Random mix of reads and writes over a small address pool.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h00100;
        1: a = 32'h00200;
        2: a = 32'h00300;
        default: a = int'($urandom_range(32'h01000, 32'h1FFFFF));
      endcase
      if ($urandom_range(0, 3) == 0)
        do_write(a, 16'($urandom), int'($urandom_range(0, 6)));
      else
        do_read(a, int'($urandom_range(0, 6)), 1'b0);
    end

    // Timeout on a withheld ack, then async reset mid-fetch.
    do_read(32'h00777, 0, 1'b1);
    cart_address = AW'(32'h00778);
    cart_cs = 1'b1; cart_oe = 1'b1;
    step();
    step();
    check_val("rst2_req", {31'd0, mem_bus.mem_req}, 32'd1);
    repeat (10) step();
    check_val("rst2_err_before", {31'd0, err_timeout}, 32'd1);
    SRES = 1'b0;
    #1;
    check_val("rst2_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    check_val("rst2_err", {31'd0, err_timeout}, 32'd0);
    check_val("rst2_busy", {31'd0, busy}, 32'd0);
    check_val("rst2_cart_data", {16'd0, cart_data}, 32'd0);
    $display("reset asserted during read wait");
    cart_cs = 1'b0; cart_oe = 1'b0;
    step();
    SRES = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
